// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

   // Unit FSM states
   typedef enum logic [2:0] {
      StIdle,
      StRdIssue,
      StRdWait,
      StWrIssue,
      StWrWait,
      StResp
   } mau_state_e;

   // RISC-V load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // RAM access size encodings
   localparam logic [1:0] OPLEN_BYTE = 2'd0;
   localparam logic [1:0] OPLEN_HALF = 2'd1;
   localparam logic [1:0] OPLEN_WORD = 2'd2;

   localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'hFFFF_FFFF;

   // Reserved encodings, plus unsigned variants that make no sense for stores
   function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
      logic ill;
      case (f3)
         3'b011, 3'b110, 3'b111: ill = 1'b1;
         default:                ill = we & f3[2];
      endcase
      return ill;
   endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte/half lane handling: load extract with sign/zero extension and store merge.
module mau_lane_align
   import mau_pkg::*;
(
   input  logic [31:0] ld_word,
   input  logic [1:0]  ld_off,
   input  logic [2:0]  ld_funct3,
   output logic [31:0] ld_data,
   input  logic [31:0] st_old,
   input  logic [31:0] st_wdata,
   input  logic [1:0]  st_off,
   input  logic [1:0]  st_oplen,
   output logic [31:0] st_new
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Select the addressed lane and extend it to a full word
   always_comb begin
      ld_byte = ld_word[{ld_off, 3'b000} +: 8];
      ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'h0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'h0, ld_half};
         default: ld_data = ld_word;
      endcase
   end

   // Overlay the low byte/half of the store data onto the old word
   always_comb begin
      st_new = st_old;
      case (st_oplen)
         OPLEN_BYTE: st_new[{st_off, 3'b000} +: 8] = st_wdata[7:0];
         OPLEN_HALF: begin
            if (st_off[1]) st_new[31:16] = st_wdata[15:0];
            else           st_new[15:0]  = st_wdata[15:0];
         end
         default:    st_new = st_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and the internal RAM.
// Word-granular RAM accesses; sub-word stores use read-modify-write.
// Optional MAU_TIMEOUT_EN adds a per-access watchdog on the wait states.
module mem_access_unit
   import mau_pkg::*;
#(
`ifdef MAU_TIMEOUT_EN
   parameter int unsigned  TIMEOUT_CYCLES = 64,
`endif
   parameter logic [31:0]  MMIO_ADDR      = MMIO_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_enable,
   output logic [31:0] mem_addr,
   output logic [1:0]  mem_oplen,
   output logic        mem_we,
   output logic [31:0] mem_data,
   input  logic [31:0] mem_result,
   input  logic        mem_valid
);

   mau_state_e  state_q;
   logic        we_q;
   logic        mmio_q;
   logic        err_q;
   logic [2:0]  f3_q;
   logic [1:0]  oplen_q;
   logic [1:0]  off_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
`ifdef MAU_TIMEOUT_EN
   logic [31:0] wait_cnt_q;
`endif

   logic        dec_mmio;
   logic        dec_illegal;
   logic        dec_misaligned;
   logic        dec_rmw;
   logic [1:0]  dec_oplen;
   logic [31:0] dec_mem_addr;
   logic [31:0] lane_rdata;
   logic [31:0] merged_word;

   // Decode the incoming request for the accept cycle
   always_comb begin
      dec_mmio       = (req_addr == MMIO_ADDR);
      dec_oplen      = req_funct3[1:0];
      dec_illegal    = f3_illegal(req_funct3, req_we);
      dec_misaligned = !dec_mmio &&
                       (((dec_oplen == OPLEN_HALF) && req_addr[0]) ||
                        ((dec_oplen == OPLEN_WORD) && (req_addr[1:0] != 2'b00)));
      dec_rmw        = req_we && !dec_mmio && (dec_oplen != OPLEN_WORD);
      dec_mem_addr   = dec_mmio ? req_addr : {req_addr[31:2], 2'b00};
   end

   mau_lane_align u_lane_align (
      .ld_word   (mem_result),
      .ld_off    (off_q),
      .ld_funct3 (f3_q),
      .ld_data   (lane_rdata),
      .st_old    (mem_result),
      .st_wdata  (wdata_q),
      .st_off    (off_q),
      .st_oplen  (oplen_q),
      .st_new    (merged_word)
   );

   // Transaction FSM with registered request/response and RAM strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_enable <= 1'b0;
         mem_addr   <= '0;
         mem_oplen  <= '0;
         mem_we     <= 1'b0;
         mem_data   <= '0;
         we_q       <= 1'b0;
         mmio_q     <= 1'b0;
         err_q      <= 1'b0;
         f3_q       <= '0;
         oplen_q    <= '0;
         off_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
`ifdef MAU_TIMEOUT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         // Strobes and response are single-cycle pulses
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_enable <= 1'b0;
         mem_addr   <= '0;
         mem_oplen  <= '0;
         mem_we     <= 1'b0;
         mem_data   <= '0;
         case (state_q)
            StIdle: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  oplen_q   <= dec_oplen;
                  off_q     <= req_addr[1:0];
                  addr_q    <= dec_mem_addr;
                  wdata_q   <= req_wdata;
                  mmio_q    <= dec_mmio;
                  rdata_q   <= '0;
                  err_q     <= 1'b0;
                  if (dec_illegal || dec_misaligned) begin
                     err_q   <= 1'b1;
                     state_q <= StResp;
                  end else begin
                     mem_enable <= 1'b1;
                     mem_addr   <= dec_mem_addr;
                     mem_oplen  <= dec_oplen;
`ifdef MAU_TIMEOUT_EN
                     wait_cnt_q <= '0;
`endif
                     if (!req_we || dec_rmw) begin
                        state_q <= StRdIssue;
                     end else begin
                        mem_we   <= 1'b1;
                        mem_data <= req_wdata;
                        state_q  <= StWrIssue;
                     end
                  end
               end
            end
            StRdIssue: state_q <= StRdWait;
            StRdWait: begin
               if (mem_valid) begin
                  if (we_q) begin
                     // Second half of read-modify-write
                     wdata_q    <= merged_word;
                     mem_enable <= 1'b1;
                     mem_we     <= 1'b1;
                     mem_addr   <= addr_q;
                     mem_oplen  <= oplen_q;
                     mem_data   <= merged_word;
`ifdef MAU_TIMEOUT_EN
                     wait_cnt_q <= '0;
`endif
                     state_q    <= StWrIssue;
                  end else begin
                     rdata_q <= mmio_q ? mem_result : lane_rdata;
                     state_q <= StResp;
                  end
               end
`ifdef MAU_TIMEOUT_EN
               else if (wait_cnt_q == TIMEOUT_CYCLES - 1) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  state_q <= StResp;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 32'd1;
               end
`endif
            end
            StWrIssue: state_q <= StWrWait;
            StWrWait: begin
               if (mem_valid) begin
                  state_q <= StResp;
               end
`ifdef MAU_TIMEOUT_EN
               else if (wait_cnt_q == TIMEOUT_CYCLES - 1) begin
                  err_q   <= 1'b1;
                  state_q <= StResp;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 32'd1;
               end
`endif
            end
            StResp: begin
               resp_valid <= 1'b1;
               resp_err   <= err_q;
               resp_rdata <= err_q ? 32'h0 : rdata_q;
               req_ready  <= 1'b1;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a 1-cycle RAM responder model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_enable;
   logic [31:0] mem_addr;
   logic [1:0]  mem_oplen;
   logic        mem_we;
   logic [31:0] mem_data;
   logic [31:0] mem_result;
   logic        mem_valid;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_enable (mem_enable),
      .mem_addr   (mem_addr),
      .mem_oplen  (mem_oplen),
      .mem_we     (mem_we),
      .mem_data   (mem_data),
      .mem_result (mem_result),
      .mem_valid  (mem_valid)
   );

   // RAM responder model
   logic [31:0] ram [16];
   logic [31:0] mmio_reg;
   logic        respond_en;
   logic        late_pulse;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
         ram[2]     <= 32'hDEADBEEF;
         mmio_reg   <= 32'h0;
         mem_valid  <= 1'b0;
         mem_result <= 32'h0;
      end else begin
         mem_valid <= (mem_enable && respond_en) || late_pulse;
         if (mem_enable && respond_en) begin
            if (mem_we) begin
               if (mem_addr == 32'hFFFFFFFF) mmio_reg <= mem_data;
               else ram[mem_addr[5:2]] <= mem_data;
            end else begin
               mem_result <= (mem_addr == 32'hFFFFFFFF) ? mmio_reg : ram[mem_addr[5:2]];
            end
         end
      end
   end

   // Bus monitor
   int          rd_cnt, wr_cnt, resp_cnt;
   logic [31:0] last_addr, last_wdata;

   always @(negedge clk) begin
      if (mem_enable) begin
         if (mem_we) begin
            wr_cnt++;
            last_wdata = mem_data;
         end else begin
            rd_cnt++;
         end
         last_addr = mem_addr;
      end
      if (resp_valid) resp_cnt++;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Issue one request; latency counts negedges from the accept edge to resp_valid
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output logic ready_after);
      rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
      last_addr = 32'h0; last_wdata = 32'h0;
      rdata = 32'hxxxxxxxx; err = 1'bx; lat = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      ready_after = req_ready;
      for (int n = 1; n <= 200; n++) begin
         if (resp_valid) begin
            lat = n; rdata = resp_rdata; err = resp_err;
            break;
         end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          rds;
      int          wrs;
      logic [31:0] maddr;
      logic [31:0] mdata;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic err, input int lat, input int rds, input int wrs,
                               input logic [31:0] maddr, input logic [31:0] mdata);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
      v.lat = lat; v.rds = rds; v.wrs = wrs; v.maddr = maddr; v.mdata = mdata;
      return v;
   endfunction

   localparam int NV = 20;
   vec_t vecs [NV];

   initial begin
      logic [31:0] got_rdata;
      logic        got_err;
      int          got_lat;
      logic        got_ready;

      //            we    f3      addr          wdata         rdata         err lat rd wr maddr         mdata
      vecs[0]  = mk(1'b0, 3'b000, 32'h9,        32'h0,        32'hFFFFFFBE, 0,  4, 1, 0, 32'h8,        32'h0);
      vecs[1]  = mk(1'b0, 3'b100, 32'h9,        32'h0,        32'h000000BE, 0,  4, 1, 0, 32'h8,        32'h0);
      vecs[2]  = mk(1'b0, 3'b001, 32'hA,        32'h0,        32'hFFFFDEAD, 0,  4, 1, 0, 32'h8,        32'h0);
      vecs[3]  = mk(1'b0, 3'b101, 32'hA,        32'h0,        32'h0000DEAD, 0,  4, 1, 0, 32'h8,        32'h0);
      vecs[4]  = mk(1'b0, 3'b010, 32'h8,        32'h0,        32'hDEADBEEF, 0,  4, 1, 0, 32'h8,        32'h0);
      vecs[5]  = mk(1'b1, 3'b000, 32'h9,        32'h55,       32'h0,        0,  6, 1, 1, 32'h8,        32'hDEAD55EF);
      vecs[6]  = mk(1'b1, 3'b001, 32'hA,        32'hCAFE,     32'h0,        0,  6, 1, 1, 32'h8,        32'hCAFE55EF);
      vecs[7]  = mk(1'b0, 3'b010, 32'h8,        32'h0,        32'hCAFE55EF, 0,  4, 1, 0, 32'h8,        32'h0);
      vecs[8]  = mk(1'b0, 3'b001, 32'h3,        32'h0,        32'h0,        1,  2, 0, 0, 32'h0,        32'h0);
      vecs[9]  = mk(1'b1, 3'b010, 32'h6,        32'h77,       32'h0,        1,  2, 0, 0, 32'h0,        32'h0);
      vecs[10] = mk(1'b0, 3'b011, 32'h8,        32'h0,        32'h0,        1,  2, 0, 0, 32'h0,        32'h0);
      vecs[11] = mk(1'b1, 3'b100, 32'h8,        32'h1,        32'h0,        1,  2, 0, 0, 32'h0,        32'h0);
      vecs[12] = mk(1'b1, 3'b010, 32'hFFFFFFFF, 32'h1234,     32'h0,        0,  4, 0, 1, 32'hFFFFFFFF, 32'h1234);
      vecs[13] = mk(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0,        32'h00001234, 0,  4, 1, 0, 32'hFFFFFFFF, 32'h0);
      vecs[14] = mk(1'b1, 3'b010, 32'h10,       32'h11223344, 32'h0,        0,  4, 0, 1, 32'h10,       32'h11223344);
      vecs[15] = mk(1'b0, 3'b000, 32'h13,       32'h0,        32'h00000011, 0,  4, 1, 0, 32'h10,       32'h0);
      vecs[16] = mk(1'b0, 3'b001, 32'h12,       32'h0,        32'h00001122, 0,  4, 1, 0, 32'h10,       32'h0);
      vecs[17] = mk(1'b0, 3'b100, 32'h10,       32'h0,        32'h00000044, 0,  4, 1, 0, 32'h10,       32'h0);
      vecs[18] = mk(1'b1, 3'b000, 32'h10,       32'hFFFFFF80, 32'h0,        0,  6, 1, 1, 32'h10,       32'h11223380);
      vecs[19] = mk(1'b0, 3'b000, 32'h10,       32'h0,        32'hFFFFFF80, 0,  4, 1, 0, 32'h10,       32'h0);

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0; respond_en = 1'b1; late_pulse = 1'b0;
      rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset req_ready", {31'h0, req_ready}, 32'h1);
      chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("reset mem_enable", {31'h0, mem_enable}, 32'h0);
      chk("reset mem_we", {31'h0, mem_we}, 32'h0);
      chk("reset mem_data", mem_data, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed vector table
      for (int i = 0; i < NV; i++) begin
         run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 got_rdata, got_err, got_lat, got_ready);
         chk($sformatf("v%0d rdata", i), got_rdata, vecs[i].rdata);
         chk($sformatf("v%0d err", i), {31'h0, got_err}, {31'h0, vecs[i].err});
         chk($sformatf("v%0d latency", i), 32'(got_lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d reads", i), 32'(rd_cnt), 32'(vecs[i].rds));
         chk($sformatf("v%0d writes", i), 32'(wr_cnt), 32'(vecs[i].wrs));
         chk($sformatf("v%0d resp count", i), 32'(resp_cnt), 32'd1);
         chk($sformatf("v%0d ready drop", i), {31'h0, got_ready}, 32'h0);
         if (vecs[i].rds + vecs[i].wrs > 0)
            chk($sformatf("v%0d mem_addr", i), last_addr, vecs[i].maddr);
         if (vecs[i].wrs > 0)
            chk($sformatf("v%0d mem_data", i), last_wdata, vecs[i].mdata);
      end

      // Reset while waiting for a write that never completes
      respond_en = 1'b0; resp_cnt = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20;
      req_wdata = 32'h77;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort req_ready", {31'h0, req_ready}, 32'h1);
      chk("abort resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("abort mem_enable", {31'h0, mem_enable}, 32'h0);
      chk("abort mem_addr", mem_addr, 32'h0);
      chk("abort mem_oplen", {30'h0, mem_oplen}, 32'h0);
      chk("abort resp_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      respond_en = 1'b1;
      late_pulse = 1'b1;
      @(negedge clk);
      late_pulse = 1'b0;
      repeat (5) @(negedge clk);
      chk("late valid resp count", 32'(resp_cnt), 32'd0);
      chk("late valid req_ready", {31'h0, req_ready}, 32'h1);

      // Unit still usable after the abort; RAM model was re-initialised by reset
      run_req(1'b0, 3'b010, 32'h8, 32'h0, got_rdata, got_err, got_lat, got_ready);
      chk("post-abort rdata", got_rdata, 32'hDEADBEEF);
      chk("post-abort latency", 32'(got_lat), 32'd4);
      chk("post-abort resp count", 32'(resp_cnt), 32'd1);

`ifdef MAU_TIMEOUT_EN
      // Responder never answers: 64 wait cycles then an error response
      respond_en = 1'b0;
      run_req(1'b0, 3'b010, 32'h8, 32'h0, got_rdata, got_err, got_lat, got_ready);
      chk("timeout err", {31'h0, got_err}, 32'h1);
      chk("timeout rdata", got_rdata, 32'h0);
      chk("timeout latency", 32'(got_lat), 32'd67);
      chk("timeout reads", 32'(rd_cnt), 32'd1);
      respond_en = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
